pixel_block_assembler: RTL

Upstream feeder for the compression core. Accepts a stream of 32-bit RGBA pixels with a valid/ready handshake and packs them into 32-pixel blocks (`types::pixels_t`). It then presents each block to the `cpu` compressor through a valid/ready handshake. Two ping-pong banks let one block be filled while the other waits on the compressor. A frame-final partial block is padded by replicating its last real pixel, which leaves the compressor's per-channel min/max unchanged.

---
 rtl/pixel_block_assembler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pixel_block_assembler.sv
// pixel_block_assembler: packs a stream of 32-bit RGBA pixels into ping-pong blocks for the
// compressor. A frame-final partial block is padded by repeating its last real pixel.

package types;
  localparam int unsigned NumPix = 32;
  localparam int unsigned NumCh  = 4;

  typedef struct packed {
    logic [NumPix-1:0][NumCh-1:0][7:0] pixels;
  } pixels_t;
endpackage

module pixel_block_assembler #(
  parameter int unsigned NPIX = 32,
  parameter int unsigned NCH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid,
  input  logic [NCH*8-1:0]     pix_data,
  input  logic                 pix_last,
  output logic                 pix_ready,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output types::pixels_t       pixels,
  output logic                 blk_last,
  output logic [5:0]           blk_npix
);

  localparam int unsigned        IdxW    = $clog2(NPIX);
  localparam logic [IdxW-1:0]    LastIdx = IdxW'(NPIX - 1);

  typedef enum logic [0:0] {StFill, StPad} state_e;

  state_e               r_state;
  state_e               w_state_next;
  types::pixels_t       r_bank [2];
  logic [1:0]           r_full;
  logic [1:0]           r_last;
  logic [5:0]           r_npix [2];
  logic                 r_wb;
  logic                 r_rb;
  logic [IdxW-1:0]      r_idx;
  logic [NCH*8-1:0]     r_padpix;

  logic                 w_accept;
  logic                 w_drain;
  logic                 w_slot_last;
  logic                 w_fill_done;

  assign w_slot_last = (r_idx == LastIdx);
  assign w_accept    = pix_valid && pix_ready;
  assign w_drain     = blk_valid && blk_ready;

  assign blk_valid = r_full[r_rb];
  assign pixels    = r_bank[r_rb];
  assign blk_last  = r_last[r_rb];
  assign blk_npix  = r_npix[r_rb];

  // Next-state, input-side ready and bank-complete decode.
  always_comb begin
    w_state_next = r_state;
    pix_ready    = 1'b0;
    w_fill_done  = 1'b0;
    unique case (r_state)
      StFill: begin
        // Ready depends only on pre-edge state, so a same-cycle drain frees the bank next cycle.
        pix_ready = !rst && !r_full[r_wb];
        if (pix_valid && pix_ready) begin
          if (w_slot_last) begin
            w_fill_done = 1'b1;
          end else if (pix_last) begin
            w_state_next = StPad;
          end
        end
      end
      StPad: begin
        if (w_slot_last) begin
          w_fill_done  = 1'b1;
          w_state_next = StFill;
        end
      end
      default: w_state_next = StFill;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StFill;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Bank storage, tags, full flags and fill/drain pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank[0] <= '0;
      r_bank[1] <= '0;
      r_npix[0] <= '0;
      r_npix[1] <= '0;
      r_full    <= '0;
      r_last    <= '0;
      r_wb      <= 1'b0;
      r_rb      <= 1'b0;
      r_idx     <= '0;
      r_padpix  <= '0;
    end else begin
      // Drain and fill-complete always target different banks, so both can land together.
      if (w_drain) begin
        r_full[r_rb] <= 1'b0;
        r_rb         <= !r_rb;
      end
      if (w_accept) begin
        r_bank[r_wb].pixels[r_idx] <= pix_data;
        r_idx                      <= r_idx + IdxW'(1);
        if (w_slot_last) begin
          r_npix[r_wb] <= 6'(NPIX);
          r_last[r_wb] <= pix_last;
        end else if (pix_last) begin
          // Repeating the last real pixel keeps per-channel min/max unchanged.
          r_padpix     <= pix_data;
          r_npix[r_wb] <= 6'(r_idx) + 6'd1;
          r_last[r_wb] <= 1'b1;
        end
      end else if (r_state == StPad) begin
        r_bank[r_wb].pixels[r_idx] <= r_padpix;
        r_idx                      <= r_idx + IdxW'(1);
      end
      if (w_fill_done) begin
        r_full[r_wb] <= 1'b1;
        r_wb         <= !r_wb;
        r_idx        <= '0;
      end
    end
  end

endmodule
